mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC memory/peripheral bus.
- Master 0 is the CPU load/store port. Master 1 is the UART boot loader/debug port, which writes program images and reads back memory.
- Sits between both masters and the shared memory/MMIO slave.
- Serialises accesses with round-robin fairness and holds the grant until the slave acknowledges.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- TIMEOUT_CYCLES, 255, busy cycles before forced completion. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous active-low reset; 0 = reset asserted.
- m0_rd  in  1  master 0 read request.
- m0_wr  in  1  master 0 write request.
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_rdata  out  DATA_WIDTH  master 0 read data, valid with m0_ack.
- m0_ack  out  1  master 0 completion strobe.
- m1_rd, m1_wr, m1_addr, m1_wdata, m1_rdata, m1_ack  same as m0_*, for master 1.
- s_rd  out  1  slave read strobe.
- s_wr  out  1  slave write strobe.
- s_addr  out  ADDR_WIDTH  slave address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_rdata  in  DATA_WIDTH  slave read data.
- s_ack  in  1  slave completion.
- grant  out  2  one-hot current owner: bit0 = M0, bit1 = M1, 00 = idle.

Behaviour:
- Request definition: reqN = mN_rd | mN_wr.
  - A master holds rd/wr, addr and wdata stable until it sees mN_ack.
  - It then deasserts, or presents a new request, on the following cycle.
- States: IDLE, OWN0, OWN1. Registers: state, last_owner (1 bit).
- Reset (reset low, asynchronous):
  - state = IDLE, last_owner = 1, so M0 wins the first tie.
  - All outputs 0: s_*, m*_ack, m*_rdata, grant = 00.
- IDLE:
  - s_rd/s_wr/s_addr/s_wdata = 0.
  - If only one master requests, go to its OWN state.
  - If both request, grant the master != last_owner.
  - With no requests, stay in IDLE.
- OWNn:
  - s_addr/s_wdata are driven combinationally from master n.
  - s_wr = mn_wr and s_rd = mn_rd & ~mn_wr; write wins if both are set.
  - The non-owner's ack and rdata are 0.
- Completion in OWNn:
  - When s_ack = 1: mn_ack = 1 in the same cycle (combinational) and mn_rdata = s_rdata.
  - mn_rdata is 0 whenever mn_ack = 0.
  - Next state = IDLE; last_owner <= n.
- Latency:
  - Request sampled in cycle k; slave strobes are visible in cycle k+1.
  - With a zero-wait slave, ack arrives in cycle k+1.
  - Minimum transaction period is 2 cycles, because IDLE is always visited between grants.
- Abort: if reqn drops while in OWNn with no s_ack, return to IDLE next cycle.
  - Strobes drop immediately (combinational).
  - last_owner <= n.
  - No ack is generated.
- s_ack while in IDLE is ignored.
- grant reflects state: OWN0 -> 01, OWN1 -> 10, IDLE -> 00.
- A slave stall holds the state indefinitely, unless ARB_TIMEOUT_EN is compiled in.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - Adds output port timeout (1 bit) and a counter of width $clog2(TIMEOUT_CYCLES+1).
  - The counter clears on entry to OWNn and increments each OWNn cycle while s_ack = 0.
  - When the count reaches TIMEOUT_CYCLES with s_ack still 0: mn_ack = 1, mn_rdata = 0, timeout = 1 for that single cycle, then go to IDLE.
  - If s_ack = 1 in the same cycle, the normal completion takes precedence and timeout stays 0.
  - Reset clears the counter and timeout.
- Without the macro: no timeout port or counter, and stalls hold indefinitely.

Test Plan:
1. Reset low mid-transaction (OWN1, s_ack = 0) -> all outputs 0 asynchronously; after release, simultaneous m0_rd/m1_rd -> M0 granted first (grant = 01).
2. M0 write addr 0x0000_0100, data 0xCAFE_F00D, zero-wait slave -> s_wr = 1, s_addr = 0x100, s_wdata = 0xCAFEF00D one cycle after request; m0_ack same cycle; next cycle grant = 00.
3. Both masters request continuously -> grants alternate 01, 00, 10, 00, 01; M1 read of 0x200 with slave data 0x1234_5678 returns m1_rdata = 0x12345678, m0_rdata = 0.
4. Slave with 3 wait states, M1 read -> s_rd held 3 cycles, m1_ack in the 4th; m0 request raised meanwhile is not granted until after IDLE.
5. M0 drops m0_wr while OWN0 without s_ack -> strobes drop immediately, no ack, IDLE next cycle; a pending M1 request is granted next.
6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, slave never acks M0 read -> m0_ack = 1, m0_rdata = 0, timeout = 1 on the 4th OWN0 cycle; grant returns to 00.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared slave.
// The arbiter takes modport "master" because it masters the slave bus; the environment uses "slave".
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_rd, m0_wr, m0_ack;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;
    logic                  m1_rd, m1_wr, m1_ack;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;
    logic                  s_rd, s_wr, s_ack;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata, s_rdata;
    logic [1:0]            grant;
`ifdef ARB_TIMEOUT_EN
    logic                  timeout;

    modport master (
        input  m0_rd, m0_wr, m0_addr, m0_wdata, m1_rd, m1_wr, m1_addr, m1_wdata, s_rdata, s_ack,
        output m0_rdata, m0_ack, m1_rdata, m1_ack, s_rd, s_wr, s_addr, s_wdata, grant, timeout
    );
    modport slave (
        output m0_rd, m0_wr, m0_addr, m0_wdata, m1_rd, m1_wr, m1_addr, m1_wdata, s_rdata, s_ack,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack, s_rd, s_wr, s_addr, s_wdata, grant, timeout
    );
`else
    modport master (
        input  m0_rd, m0_wr, m0_addr, m0_wdata, m1_rd, m1_wr, m1_addr, m1_wdata, s_rdata, s_ack,
        output m0_rdata, m0_ack, m1_rdata, m1_ack, s_rd, s_wr, s_addr, s_wdata, grant
    );
    modport slave (
        output m0_rd, m0_wr, m0_addr, m0_wdata, m1_rd, m1_wr, m1_addr, m1_wdata, s_rdata, s_ack,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack, s_rd, s_wr, s_addr, s_wdata, grant
    );
`endif
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory/MMIO slave; grant held until slave ack.
// Optional ARB_TIMEOUT_EN: force-completes a stalled access after TIMEOUT_CYCLES owner cycles.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           reset,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state_q;
    logic       last_q;
    logic [1:0] grant_q;
    logic       req0, req1, done0, done1;

    logic [ADDR_WIDTH-1:0] s_addr_d;
    logic [DATA_WIDTH-1:0] s_wdata_d, m0_rdata_d, m1_rdata_d;

    assign req0 = bus.m0_rd | bus.m0_wr;
    assign req1 = bus.m1_rd | bus.m1_wr;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter is cleared on entry, so the last allowed owner cycle sees TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             tmo_hit;
    assign tmo_hit = (cnt_q == CNT_LAST) && !bus.s_ack;
`endif

    always_comb begin
        bus.s_rd    = 1'b0;
        bus.s_wr    = 1'b0;
        s_addr_d    = '0;
        s_wdata_d   = '0;
        bus.m0_ack  = 1'b0;
        bus.m1_ack  = 1'b0;
        m0_rdata_d  = '0;
        m1_rdata_d  = '0;
`ifdef ARB_TIMEOUT_EN
        bus.timeout = 1'b0;
`endif
        case (state_q)
            OWN0: begin
                bus.s_wr  = bus.m0_wr;
                bus.s_rd  = bus.m0_rd & ~bus.m0_wr;
                s_addr_d  = bus.m0_addr;
                s_wdata_d = bus.m0_wdata;
                if (bus.s_ack) begin
                    bus.m0_ack = 1'b1;
                    m0_rdata_d = bus.s_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit && req0) begin
                    bus.m0_ack  = 1'b1;
                    bus.timeout = 1'b1;
                end
`endif
            end
            OWN1: begin
                bus.s_wr  = bus.m1_wr;
                bus.s_rd  = bus.m1_rd & ~bus.m1_wr;
                s_addr_d  = bus.m1_addr;
                s_wdata_d = bus.m1_wdata;
                if (bus.s_ack) begin
                    bus.m1_ack = 1'b1;
                    m1_rdata_d = bus.s_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit && req1) begin
                    bus.m1_ack  = 1'b1;
                    bus.timeout = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    assign bus.s_addr   = s_addr_d;
    assign bus.s_wdata  = s_wdata_d;
    assign bus.m0_rdata = m0_rdata_d;
    assign bus.m1_rdata = m1_rdata_d;
    assign bus.grant    = grant_q;

    // An owner is released on completion or when it withdraws its request (abort).
    assign done0 = bus.m0_ack | ~req0;
    assign done1 = bus.m1_ack | ~req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= OWN0;
                        grant_q <= 2'b01;
                    end else if (req1) begin
                        state_q <= OWN1;
                        grant_q <= 2'b10;
                    end
                end
                OWN0: begin
                    if (done0) begin
                        state_q <= IDLE;
                        last_q  <= 1'b0;
                        grant_q <= 2'b00;
                    end
`ifdef ARB_TIMEOUT_EN
                    else cnt_q <= cnt_q + 1'b1;
`endif
                end
                OWN1: begin
                    if (done1) begin
                        state_q <= IDLE;
                        last_q  <= 1'b1;
                        grant_q <= 2'b00;
                    end
`ifdef ARB_TIMEOUT_EN
                    else cnt_q <= cnt_q + 1'b1;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, grants, fairness, wait states, abort and optional timeout.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g [5];
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        bus.m0_rd = 0; bus.m0_wr = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_rd = 0; bus.m1_wr = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.s_rdata = '0; bus.s_ack = 0;

        // reset state, then async reset in the middle of an M1 ownership
        step(); step();
        #1 chk("rst_grant", bus.grant, 2'b00);
        chk("rst_s_rd", bus.s_rd, 0);
        chk("rst_m0_ack", bus.m0_ack, 0);
        reset = 1'b1;
        step();
        bus.m1_rd = 1; bus.m1_addr = 32'h300;
        step();
        #1 chk("t1_own1_grant", bus.grant, 2'b10);
        chk("t1_own1_s_rd", bus.s_rd, 1);
        chk("t1_own1_s_addr", bus.s_addr, 32'h300);
        reset = 1'b0;
        #1 chk("t1_async_grant", bus.grant, 2'b00);
        chk("t1_async_s_rd", bus.s_rd, 0);
        chk("t1_async_s_addr", bus.s_addr, 0);
        bus.s_ack = 1; bus.s_rdata = 32'hBAD;
        #1 chk("t1_async_m1_ack", bus.m1_ack, 0);
        chk("t1_async_m1_rdata", bus.m1_rdata, 0);
        bus.s_ack = 0; bus.s_rdata = '0; bus.m1_rd = 0;
        step();
        reset = 1'b1;
        bus.m0_rd = 1; bus.m1_rd = 1; bus.m0_addr = 32'h10; bus.m1_addr = 32'h20;
        step();
        #1 chk("t1_tie_grant", bus.grant, 2'b01);
        chk("t1_tie_s_addr", bus.s_addr, 32'h10);
        chk("t1_tie_s_rd", bus.s_rd, 1);
        bus.s_ack = 1; bus.s_rdata = 32'hAAAA_5555;
        #1 chk("t1_m0_ack", bus.m0_ack, 1);
        chk("t1_m0_rdata", bus.m0_rdata, 32'hAAAA_5555);
        chk("t1_m1_ack", bus.m1_ack, 0);
        chk("t1_m1_rdata", bus.m1_rdata, 0);
        step();
        bus.m0_rd = 0; bus.m1_rd = 0; bus.s_ack = 0; bus.s_rdata = '0;
        #1 chk("t1_idle_grant", bus.grant, 2'b00);

        // M0 write with zero-wait slave
        bus.m0_wr = 1; bus.m0_addr = 32'h100; bus.m0_wdata = 32'hCAFE_F00D;
        step();
        #1 chk("t2_s_wr", bus.s_wr, 1);
        chk("t2_s_rd", bus.s_rd, 0);
        chk("t2_s_addr", bus.s_addr, 32'h100);
        chk("t2_s_wdata", bus.s_wdata, 32'hCAFE_F00D);
        chk("t2_grant", bus.grant, 2'b01);
        chk("t2_ack_early", bus.m0_ack, 0);
        bus.s_ack = 1;
        #1 chk("t2_m0_ack", bus.m0_ack, 1);
        step();
        bus.m0_wr = 0; bus.s_ack = 0;
        #1 chk("t2_idle_grant", bus.grant, 2'b00);
        chk("t2_idle_s_wr", bus.s_wr, 0);
        chk("t2_idle_s_wdata", bus.s_wdata, 0);

        // M1 read with 3 wait states; M0 request raised meanwhile
        bus.m1_rd = 1; bus.m1_addr = 32'h400;
        step();
        #1 chk("t4_c1_s_rd", bus.s_rd, 1);
        chk("t4_c1_grant", bus.grant, 2'b10);
        chk("t4_c1_ack", bus.m1_ack, 0);
        bus.m0_wr = 1; bus.m0_addr = 32'h44; bus.m0_wdata = 32'h77;
        step();
        #1 chk("t4_c2_s_rd", bus.s_rd, 1);
        chk("t4_c2_grant", bus.grant, 2'b10);
        chk("t4_c2_ack", bus.m1_ack, 0);
        step();
        #1 chk("t4_c3_s_rd", bus.s_rd, 1);
        chk("t4_c3_ack", bus.m1_ack, 0);
        step();
        bus.s_ack = 1; bus.s_rdata = 32'h55;
        #1 chk("t4_c4_m1_ack", bus.m1_ack, 1);
        chk("t4_c4_m1_rdata", bus.m1_rdata, 32'h55);
        chk("t4_c4_m0_ack", bus.m0_ack, 0);
        chk("t4_c4_s_addr", bus.s_addr, 32'h400);
        step();
        bus.m1_rd = 0; bus.s_ack = 0; bus.s_rdata = '0;
        #1 chk("t4_idle_grant", bus.grant, 2'b00);
        chk("t4_idle_s_wr", bus.s_wr, 0);
        step();
        #1 chk("t4_m0_grant", bus.grant, 2'b01);
        chk("t4_m0_s_wr", bus.s_wr, 1);
        chk("t4_m0_s_addr", bus.s_addr, 32'h44);

        // M0 aborts its write; pending M1 gets the bus next
        bus.m1_rd = 1; bus.m1_addr = 32'h200;
        #1 bus.m0_wr = 0;
        #1 chk("t5_abort_s_wr", bus.s_wr, 0);
        chk("t5_abort_s_rd", bus.s_rd, 0);
        chk("t5_abort_ack", bus.m0_ack, 0);
        step();
        #1 chk("t5_idle_grant", bus.grant, 2'b00);
        step();
        #1 chk("t5_m1_grant", bus.grant, 2'b10);
        chk("t5_m1_s_addr", bus.s_addr, 32'h200);
        chk("t5_m1_s_rd", bus.s_rd, 1);
        bus.s_ack = 1; bus.s_rdata = 32'h1234_5678;
        #1 chk("t5_m1_ack", bus.m1_ack, 1);
        chk("t5_m1_rdata", bus.m1_rdata, 32'h1234_5678);
        chk("t5_m0_rdata", bus.m0_rdata, 0);
        step();
        bus.m1_rd = 0; bus.s_ack = 0; bus.s_rdata = '0;

        // both masters request continuously: grants alternate
        bus.m0_rd = 1; bus.m1_rd = 1; bus.m0_addr = 32'h80; bus.m1_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.s_ack   = (exp_g[i] != 2'b00);
            bus.s_rdata = (exp_g[i] == 2'b10) ? 32'h1234_5678 : 32'hA5A5_0000;
            #1 chk($sformatf("t3_grant_%0d", i), bus.grant, exp_g[i]);
            if (exp_g[i] == 2'b01) begin
                chk($sformatf("t3_m0_rdata_%0d", i), bus.m0_rdata, 32'hA5A5_0000);
                chk($sformatf("t3_m1_rdata_%0d", i), bus.m1_rdata, 0);
            end else if (exp_g[i] == 2'b10) begin
                chk($sformatf("t3_m1_rdata_%0d", i), bus.m1_rdata, 32'h1234_5678);
                chk($sformatf("t3_m0_rdata_%0d", i), bus.m0_rdata, 0);
            end
        end
        step();
        bus.m0_rd = 0; bus.m1_rd = 0; bus.s_ack = 0; bus.s_rdata = '0;
        #1 chk("t3_end_grant", bus.grant, 2'b00);

`ifdef ARB_TIMEOUT_EN
        // slave never acks: forced completion on the 4th owner cycle
        bus.m0_rd = 1; bus.m0_addr = 32'h900; bus.s_rdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 4; c++) begin
            step();
            #1 chk($sformatf("t6_timeout_c%0d", c), bus.timeout, (c == 4));
            chk($sformatf("t6_m0_ack_c%0d", c), bus.m0_ack, (c == 4));
            chk($sformatf("t6_grant_c%0d", c), bus.grant, 2'b01);
        end
        chk("t6_m0_rdata", bus.m0_rdata, 0);
        step();
        bus.m0_rd = 0;
        #1 chk("t6_idle_grant", bus.grant, 2'b00);
        chk("t6_idle_timeout", bus.timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
